// File: rtl/hx8352_init_seq_pkg.sv
// Shared types for the HX8352 power-up sequencer: ROM entry layout, opcodes, FSM states.
package hx8352_pkg;

    localparam int ENTRY_W = 18;
    localparam int ARG_W   = 16;
    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 16;
    localparam int ARG_MSB = 15;
    localparam int ARG_LSB = 0;

    typedef enum logic [1:0] {
        OP_CMD = 2'b00,
        OP_DAT = 2'b01,
        OP_DLY = 2'b10,
        OP_END = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WRITE,
        ST_DLY_ARM,
        ST_DLY_SETTLE,
        ST_DLY_WAIT,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic entry_t mk_entry(input op_e op, input logic [ARG_W-1:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/hx8352_init_seq_if.sv
// Panel-writer req/ack bus plus the delay-timer step/length/done link, seen from the sequencer.
interface hx8352_init_seq_if;
    import hx8352_pkg::*;

    logic             wr_req;
    logic             wr_rs;
    logic [ARG_W-1:0] wr_data;
    logic             wr_ack;
    logic             dly_step;
    logic [ARG_W-1:0] dly_us;
    logic             dly_done;

    modport master (
        output wr_req, wr_rs, wr_data, dly_step, dly_us,
        input  wr_ack, dly_done
    );

    modport slave (
        input  wr_req, wr_rs, wr_data, dly_step, dly_us,
        output wr_ack, dly_done
    );

endinterface

// File: rtl/hx8352_init_rom.sv
// Synchronous-read init table (1-cycle latency). USE_IMAGE swaps the built-in HX8352
// table for a caller-supplied flat image, entry i at bits [i*ENTRY_W +: ENTRY_W].
module hx8352_init_rom
    import hx8352_pkg::*;
#(
    parameter int ROM_AW = 6,
    parameter bit USE_IMAGE = 1'b0,
    parameter logic [(2**ROM_AW)*ENTRY_W-1:0] ROM_IMAGE = '0
) (
    input  logic              clk_1MHz,
    input  logic [ROM_AW-1:0] addr,
    output entry_t            q
);

    // Delays are in microseconds, so 100 ms waits are split across two entries.
    function automatic entry_t builtin_entry(input int idx);
        entry_t e;
        e = mk_entry(OP_END, 16'h0000);
        case (idx)
            0:  e = mk_entry(OP_CMD, 16'h0083);
            1:  e = mk_entry(OP_DAT, 16'h0002);
            2:  e = mk_entry(OP_CMD, 16'h0085);
            3:  e = mk_entry(OP_DAT, 16'h0003);
            4:  e = mk_entry(OP_CMD, 16'h008B);
            5:  e = mk_entry(OP_DAT, 16'h0001);
            6:  e = mk_entry(OP_CMD, 16'h008C);
            7:  e = mk_entry(OP_DAT, 16'h0093);
            8:  e = mk_entry(OP_CMD, 16'h0091);
            9:  e = mk_entry(OP_DAT, 16'h0001);
            10: e = mk_entry(OP_CMD, 16'h0083);
            11: e = mk_entry(OP_DAT, 16'h0000);
            12: e = mk_entry(OP_CMD, 16'h0017);
            13: e = mk_entry(OP_DAT, 16'h0005);
            14: e = mk_entry(OP_CMD, 16'h002B);
            15: e = mk_entry(OP_DAT, 16'h00F9);
            16: e = mk_entry(OP_DLY, 16'd10000);
            17: e = mk_entry(OP_CMD, 16'h001B);
            18: e = mk_entry(OP_DAT, 16'h0014);
            19: e = mk_entry(OP_CMD, 16'h001A);
            20: e = mk_entry(OP_DAT, 16'h0011);
            21: e = mk_entry(OP_CMD, 16'h001C);
            22: e = mk_entry(OP_DAT, 16'h0006);
            23: e = mk_entry(OP_CMD, 16'h001F);
            24: e = mk_entry(OP_DAT, 16'h0042);
            25: e = mk_entry(OP_DLY, 16'd20000);
            26: e = mk_entry(OP_CMD, 16'h0019);
            27: e = mk_entry(OP_DAT, 16'h000A);
            28: e = mk_entry(OP_CMD, 16'h0019);
            29: e = mk_entry(OP_DAT, 16'h001A);
            30: e = mk_entry(OP_DLY, 16'd40000);
            31: e = mk_entry(OP_CMD, 16'h0019);
            32: e = mk_entry(OP_DAT, 16'h0012);
            33: e = mk_entry(OP_DLY, 16'd40000);
            34: e = mk_entry(OP_CMD, 16'h001E);
            35: e = mk_entry(OP_DAT, 16'h0027);
            36: e = mk_entry(OP_DLY, 16'd50000);
            37: e = mk_entry(OP_DLY, 16'd50000);
            38: e = mk_entry(OP_CMD, 16'h0024);
            39: e = mk_entry(OP_DAT, 16'h0060);
            40: e = mk_entry(OP_CMD, 16'h003D);
            41: e = mk_entry(OP_DAT, 16'h0040);
            42: e = mk_entry(OP_CMD, 16'h0034);
            43: e = mk_entry(OP_DAT, 16'h0038);
            44: e = mk_entry(OP_CMD, 16'h0035);
            45: e = mk_entry(OP_DAT, 16'h0038);
            46: e = mk_entry(OP_CMD, 16'h0024);
            47: e = mk_entry(OP_DAT, 16'h0038);
            48: e = mk_entry(OP_DLY, 16'd40000);
            49: e = mk_entry(OP_CMD, 16'h0024);
            50: e = mk_entry(OP_DAT, 16'h003C);
            51: e = mk_entry(OP_CMD, 16'h0016);
            52: e = mk_entry(OP_DAT, 16'h001C);
            53: e = mk_entry(OP_CMD, 16'h0001);
            54: e = mk_entry(OP_DAT, 16'h0006);
            55: e = mk_entry(OP_CMD, 16'h0055);
            56: e = mk_entry(OP_DAT, 16'h0000);
            57: e = mk_entry(OP_CMD, 16'h0022);
            default: e = mk_entry(OP_END, 16'h0000);
        endcase
        return e;
    endfunction

    entry_t q_d;
    entry_t q_q;

    always_comb begin
        q_d = builtin_entry(int'(addr));
        if (USE_IMAGE) begin
            q_d = ROM_IMAGE[ENTRY_W*int'(addr) +: ENTRY_W];
        end
    end

    always_ff @(posedge clk_1MHz) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/hx8352_init_seq.sv
// HX8352 power-up sequencer: walks the init ROM, issuing panel writes over req/ack and
// delays to the microsecond timer; wr_req is held until wr_ack, delays wait on dly_done.
module hx8352_init_seq
    import hx8352_pkg::*;
#(
    parameter int ROM_AW = 6,
    parameter bit USE_IMAGE = 1'b0,
    parameter logic [(2**ROM_AW)*ENTRY_W-1:0] ROM_IMAGE = '0
) (
    input  logic               clk_1MHz,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               init_done,
    hx8352_init_seq_if.master  bus
);

    localparam logic [ROM_AW-1:0] PC_LAST = '1;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] pc_q, pc_d;
    logic [ARG_W-1:0]  wr_data_q, wr_data_d;
    logic              wr_rs_q, wr_rs_d;
    logic [ARG_W-1:0]  dly_us_q, dly_us_d;

    entry_t            rom_q;
    op_e               op;
    logic [ARG_W-1:0]  arg;

    hx8352_init_rom #(
        .ROM_AW    (ROM_AW),
        .USE_IMAGE (USE_IMAGE),
        .ROM_IMAGE (ROM_IMAGE)
    ) u_rom (
        .clk_1MHz (clk_1MHz),
        .addr     (pc_q),
        .q        (rom_q)
    );

    assign op  = op_e'(rom_q[OP_MSB:OP_LSB]);
    assign arg = rom_q[ARG_MSB:ARG_LSB];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wr_data_d = wr_data_q;
        wr_rs_d   = wr_rs_q;
        dly_us_d  = dly_us_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_CMD, OP_DAT: begin
                        wr_data_d = arg;
                        wr_rs_d   = (op == OP_DAT);
                        state_d   = ST_WRITE;
                    end
                    OP_DLY: begin
                        dly_us_d = arg;
                        state_d  = ST_DLY_ARM;
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_WRITE: begin
                if (bus.wr_ack) begin
                    state_d = ST_NEXT;
                end
            end
            ST_DLY_ARM: state_d = ST_DLY_SETTLE;
            // done from the previous delay may still be high while the timer reloads
            ST_DLY_SETTLE: state_d = ST_DLY_WAIT;
            ST_DLY_WAIT: begin
                if (bus.dly_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (pc_q == PC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + ROM_AW'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            wr_data_q <= '0;
            wr_rs_q   <= 1'b0;
            dly_us_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wr_data_q <= wr_data_d;
            wr_rs_q   <= wr_rs_d;
            dly_us_q  <= dly_us_d;
        end
    end

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign init_done    = (state_q == ST_DONE);
    assign bus.wr_req   = (state_q == ST_WRITE);
    assign bus.wr_rs    = wr_rs_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.dly_step = (state_q == ST_DLY_ARM);
    assign bus.dly_us   = dly_us_q;

endmodule
